instruction_fetch_queue: RTL and testbench

Parametrised next-generation instruction fetch stage that decouples I-cache fetch from decode through a DEPTH-entry instruction queue. It fetches ahead along the predicted path: jal targets are resolved locally, branches are steered by the predictor, and jalr stalls fetch until the RoB supplies the target. It sits between ICache, Predictor, Decoder and RoB, and its port protocol toward each of them matches the previous fetcher. A RoB misprediction flushes the queue and discards any in-flight I-cache response.

---
 rtl/instruction_fetch_queue.sv | 135 +++++++++++++
 tb/tb_instruction_fetch_queue.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_queue.sv
// instruction_fetch_queue: predicted-path fetch stage feeding decode through a DEPTH-entry queue
// Ports: Sys_clk clock, Sys_rst sync active-high reset, Sys_rdy global enable;
//   ICIF_*/IFIC_* I-cache response/request; DCIF_ask_IF/IFDC_* decoder handshake and instruction;
//   PDIF_*/IFPD_* predictor query, prediction and resolved-branch feedback;
//   RoBIF_* jalr target, branch resolution and misprediction flush.
// Macro IFQ_BYPASS_EN: hand a response straight to decode when the queue is empty.
module instruction_fetch_queue #(
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int PTR_WIDTH = 2
) (
  input  logic                  Sys_clk,
  input  logic                  Sys_rst,
  input  logic                  Sys_rdy,
  input  logic                  ICIF_en,
  input  logic [31:0]           ICIF_data,
  output logic                  IFIC_en,
  output logic [ADDR_WIDTH-1:0] IFIC_addr,
  input  logic                  DCIF_ask_IF,
  output logic                  IFDC_en,
  output logic [ADDR_WIDTH-1:0] IFDC_pc,
  output logic [6:0]            IFDC_opcode,
  output logic [24:0]           IFDC_remain_inst,
  output logic                  IFDC_predict_result,
  output logic                  IFPD_predict_en,
  output logic [ADDR_WIDTH-1:0] IFPD_pc,
  input  logic                  PDIF_predict_result,
  output logic                  IFPD_feedback_en,
  output logic                  IFPD_branch_result,
  output logic [ADDR_WIDTH-1:0] IFPD_feedback_pc,
  input  logic                  RoBIF_jalr_en,
  input  logic                  RoBIF_branch_en,
  input  logic                  RoBIF_pre_judge,
  input  logic                  RoBIF_branch_result,
  input  logic [ADDR_WIDTH-1:0] RoBIF_branch_pc,
  input  logic [ADDR_WIDTH-1:0] RoBIF_next_pc
);
  typedef enum logic [1:0] {REQ, WAIT_JALR, DRAIN} state_t;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BR = 7'b1100011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [PTR_WIDTH:0] FULL = (PTR_WIDTH + 1)'(DEPTH);
  state_t state, state_nxt;
  logic [ADDR_WIDTH-1:0] pc, pc_nxt, j_imm, b_imm;
  logic [ADDR_WIDTH-1:0] q_pc [DEPTH];
  logic [31:0] q_inst [DEPTH];
  logic [DEPTH-1:0] q_pred;
  logic [PTR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [PTR_WIDTH:0] count;
  logic [6:0] op;
  logic flush, accept, push, pop, byp, outstanding, pred_in;
  assign op = ICIF_data[6:0];
  assign j_imm = {{(ADDR_WIDTH-20){ICIF_data[31]}}, ICIF_data[19:12], ICIF_data[20], ICIF_data[30:21], 1'b0};
  assign b_imm = {{(ADDR_WIDTH-12){ICIF_data[31]}}, ICIF_data[7], ICIF_data[30:25], ICIF_data[11:8], 1'b0};
  assign flush = !RoBIF_pre_judge;
  assign accept = ICIF_en && IFIC_en;
  // a response still owed by the I-cache must be swallowed after a redirect
  assign outstanding = (IFIC_en || state == DRAIN) && !ICIF_en;
  assign pred_in = op == OP_BR && PDIF_predict_result;
`ifdef IFQ_BYPASS_EN
  assign byp = accept && !flush && count == '0 && DCIF_ask_IF;
`else
  assign byp = 1'b0;
`endif
  assign push = accept && !flush && !byp;
  assign pop = DCIF_ask_IF && count != '0 && !flush;
  assign IFIC_addr = pc;
  assign IFPD_pc = pc;
  assign IFPD_predict_en = ICIF_en && state == REQ && op == OP_BR;
  always_ff @(posedge Sys_clk)
    if (Sys_rst) state <= REQ;
    else if (Sys_rdy) state <= state_nxt;
  always_comb
    state_nxt = flush ? (outstanding ? DRAIN : REQ)
      : (state == REQ && accept && op == OP_JALR) ? WAIT_JALR
      : ((state == WAIT_JALR && RoBIF_jalr_en) || (state == DRAIN && ICIF_en)) ? REQ
      : state;
  always_comb
    IFIC_en = state == REQ && count != FULL;
  always_comb
    pc_nxt = flush ? RoBIF_next_pc
      : (state == WAIT_JALR && RoBIF_jalr_en) ? RoBIF_next_pc
      : !accept ? pc
      : op == OP_JAL ? pc + j_imm
      : op == OP_BR ? pc + (PDIF_predict_result ? b_imm : ADDR_WIDTH'(4))
      : op == OP_JALR ? pc
      : pc + ADDR_WIDTH'(4);
  always_ff @(posedge Sys_clk)
    if (Sys_rdy && push) begin
      q_pc[wr_ptr] <= pc;
      q_inst[wr_ptr] <= ICIF_data;
      q_pred[wr_ptr] <= pred_in;
    end
  always_ff @(posedge Sys_clk)
    if (Sys_rst) begin
      pc <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      IFDC_en <= 1'b0;
      IFDC_pc <= '0;
      IFDC_opcode <= '0;
      IFDC_remain_inst <= '0;
      IFDC_predict_result <= 1'b0;
      IFPD_feedback_en <= 1'b0;
      IFPD_branch_result <= 1'b0;
      IFPD_feedback_pc <= '0;
    end else if (Sys_rdy) begin
      pc <= pc_nxt;
      IFPD_feedback_en <= RoBIF_branch_en;
      IFPD_branch_result <= RoBIF_branch_result;
      IFPD_feedback_pc <= RoBIF_branch_pc;
      IFDC_en <= pop || byp;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_WIDTH'(1);
        if (pop) rd_ptr <= rd_ptr + PTR_WIDTH'(1);
        count <= count + (PTR_WIDTH + 1)'(push) - (PTR_WIDTH + 1)'(pop);
      end
      if (pop) begin
        IFDC_pc <= q_pc[rd_ptr];
        IFDC_opcode <= q_inst[rd_ptr][6:0];
        IFDC_remain_inst <= q_inst[rd_ptr][31:7];
        IFDC_predict_result <= q_pred[rd_ptr];
      end else if (byp) begin
        IFDC_pc <= pc;
        IFDC_opcode <= op;
        IFDC_remain_inst <= ICIF_data[31:7];
        IFDC_predict_result <= pred_in;
      end
    end
endmodule

// File: tb/tb_instruction_fetch_queue.sv
// tb_instruction_fetch_queue: vector table, corner sequences and randomized scoreboard run
module tb_instruction_fetch_queue;
  localparam int AW = 32;
  localparam int DEPTH = 4;
`ifdef IFQ_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif
  localparam logic [31:0] ADDI = 32'h00100093;
  localparam logic [31:0] JALR = 32'h000080e7;
  logic Sys_clk = 0, Sys_rst = 1, Sys_rdy = 1;
  logic ICIF_en = 0, DCIF_ask_IF = 0, PDIF_predict_result = 0;
  logic [31:0] ICIF_data = 0;
  logic RoBIF_jalr_en = 0, RoBIF_branch_en = 0, RoBIF_pre_judge = 1, RoBIF_branch_result = 0;
  logic [AW-1:0] RoBIF_branch_pc = 0, RoBIF_next_pc = 0;
  logic IFIC_en, IFDC_en, IFDC_predict_result, IFPD_predict_en, IFPD_feedback_en, IFPD_branch_result;
  logic [AW-1:0] IFIC_addr, IFDC_pc, IFPD_pc, IFPD_feedback_pc;
  logic [6:0] IFDC_opcode;
  logic [24:0] IFDC_remain_inst;
  instruction_fetch_queue #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .PTR_WIDTH(2)) dut (
    .Sys_clk(Sys_clk), .Sys_rst(Sys_rst), .Sys_rdy(Sys_rdy),
    .ICIF_en(ICIF_en), .ICIF_data(ICIF_data), .IFIC_en(IFIC_en), .IFIC_addr(IFIC_addr),
    .DCIF_ask_IF(DCIF_ask_IF), .IFDC_en(IFDC_en), .IFDC_pc(IFDC_pc), .IFDC_opcode(IFDC_opcode),
    .IFDC_remain_inst(IFDC_remain_inst), .IFDC_predict_result(IFDC_predict_result),
    .IFPD_predict_en(IFPD_predict_en), .IFPD_pc(IFPD_pc), .PDIF_predict_result(PDIF_predict_result),
    .IFPD_feedback_en(IFPD_feedback_en), .IFPD_branch_result(IFPD_branch_result),
    .IFPD_feedback_pc(IFPD_feedback_pc), .RoBIF_jalr_en(RoBIF_jalr_en),
    .RoBIF_branch_en(RoBIF_branch_en), .RoBIF_pre_judge(RoBIF_pre_judge),
    .RoBIF_branch_result(RoBIF_branch_result), .RoBIF_branch_pc(RoBIF_branch_pc),
    .RoBIF_next_pc(RoBIF_next_pc)
  );
  always #5 Sys_clk = ~Sys_clk;
  int checks = 0, errors = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge Sys_clk);
    #1;
  endtask
  task automatic do_reset;
    Sys_rst = 1; Sys_rdy = 1; ICIF_en = 0; DCIF_ask_IF = 0; RoBIF_jalr_en = 0;
    RoBIF_branch_en = 0; RoBIF_pre_judge = 1; PDIF_predict_result = 0;
    tick; tick;
    Sys_rst = 0;
  endtask
  task automatic wait_dc(input string name, input logic [31:0] epc, input logic [31:0] einst, input logic epred);
    int n = 0;
    while (!IFDC_en && n < 20) begin tick; n++; end
    check({name, " IFDC_en"}, IFDC_en, 1);
    check({name, " IFDC_pc"}, IFDC_pc, epc);
    check({name, " inst"}, {IFDC_remain_inst, IFDC_opcode}, einst);
    check({name, " pred"}, IFDC_predict_result, epred);
  endtask
  function automatic logic [31:0] enc_j(input int imm);
    logic [20:0] i;
    i = 21'(imm);
    return {i[20], i[10:1], i[11], i[19:12], 5'd1, 7'b1101111};
  endfunction
  function automatic logic [31:0] enc_b(input int imm);
    logic [12:0] i;
    i = 13'(imm);
    return {i[12], i[10:5], 5'd2, 5'd1, 3'b000, i[4:1], i[11], 7'b1100011};
  endfunction
  typedef struct {
    logic [31:0] start, inst, nxt;
    logic pred, pen, ifen, dpred;
  } vec_t;
  typedef struct {
    logic [31:0] pc, inst;
    logic pred;
  } ent_t;
  vec_t v[8];
  ent_t q[$];
  ent_t e;
  logic [31:0] epc, tgt;
  bit waiting, draining, busy, exp_ifen, resp, fl, je, isbr, pben, pbres;
  logic [31:0] pbpc;
  int lat, jcnt, kind, imm;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    do_reset;
    check("reset IFDC_en", IFDC_en, 0);
    check("reset IFDC_pc", IFDC_pc, 0);
    check("reset IFDC_inst", {IFDC_remain_inst, IFDC_opcode}, 0);
    check("reset IFDC_pred", IFDC_predict_result, 0);
    check("reset feedback", {IFPD_feedback_en, IFPD_branch_result}, 0);
    check("reset feedback_pc", IFPD_feedback_pc, 0);
    check("reset IFIC_en", IFIC_en, 1);
    check("reset IFIC_addr", IFIC_addr, 0);
    // straight-line stream, back-to-back responses
    DCIF_ask_IF = 1; ICIF_data = ADDI;
    for (int s = 0; s < 5; s++) begin
      ICIF_en = s < 3;
      if (s < 3) check("line IFIC_addr", IFIC_addr, 32'(4 * s));
      tick;
      check("line IFDC_en", IFDC_en, 32'(s >= LAT - 1 && s < LAT + 2));
      if (s >= LAT - 1 && s < LAT + 2) check("line IFDC_pc", IFDC_pc, 32'(4 * (s - LAT + 1)));
    end
    ICIF_en = 0;
    // fill to DEPTH with decode stalled, then drain in order
    do_reset;
    ICIF_data = ADDI;
    for (int s = 0; s < 6; s++) begin
      check("fill IFIC_en", IFIC_en, 32'(s < DEPTH));
      ICIF_en = IFIC_en;
      tick;
    end
    ICIF_en = 0; DCIF_ask_IF = 1;
    for (int k = 0; k < DEPTH; k++) begin
      tick;
      check("drain IFDC_en", IFDC_en, 1);
      check("drain IFDC_pc", IFDC_pc, 32'(4 * k));
    end
    check("resume IFIC_en", IFIC_en, 1);
    check("resume IFIC_addr", IFIC_addr, 16);
    tick;
    check("empty IFDC_en", IFDC_en, 0);
    // jalr stalls fetch until the RoB target
    do_reset;
    ICIF_en = 1; ICIF_data = JALR;
    tick;
    ICIF_en = 0;
    for (int k = 0; k < 4; k++) begin
      check("jalr stall IFIC_en", IFIC_en, 0);
      tick;
    end
    RoBIF_jalr_en = 1; RoBIF_next_pc = 32'h100;
    tick;
    RoBIF_jalr_en = 0;
    check("jalr IFIC_en", IFIC_en, 1);
    check("jalr IFIC_addr", IFIC_addr, 32'h100);
    // flush with 3 queued and a request outstanding
    do_reset;
    ICIF_data = ADDI;
    for (int k = 0; k < 3; k++) begin
      ICIF_en = 1;
      check("pre-flush IFIC_addr", IFIC_addr, 32'(4 * k));
      tick;
    end
    ICIF_en = 0;
    check("pre-flush IFIC_en", IFIC_en, 1);
    RoBIF_pre_judge = 0; RoBIF_next_pc = 32'h200; DCIF_ask_IF = 1;
    RoBIF_branch_en = 1; RoBIF_branch_result = 1; RoBIF_branch_pc = 32'h8;
    tick;
    RoBIF_pre_judge = 1; RoBIF_branch_en = 0; RoBIF_branch_result = 0;
    check("flush IFIC_en", IFIC_en, 0);
    check("flush IFDC_en", IFDC_en, 0);
    check("flush feedback_en", IFPD_feedback_en, 1);
    check("flush branch_result", IFPD_branch_result, 1);
    check("flush feedback_pc", IFPD_feedback_pc, 32'h8);
    tick;
    check("flush feedback_en off", IFPD_feedback_en, 0);
    check("flush empty IFDC_en", IFDC_en, 0);
    ICIF_en = 1; ICIF_data = enc_b(64); PDIF_predict_result = 1;
    #1;
    check("stale predict_en", IFPD_predict_en, 0);
    tick;
    ICIF_en = 0;
    check("post-drain IFIC_en", IFIC_en, 1);
    check("post-drain IFIC_addr", IFIC_addr, 32'h200);
    check("stale IFDC_en", IFDC_en, 0);
    tick;
    check("stale IFDC_en 2", IFDC_en, 0);
    Sys_rdy = 0; RoBIF_pre_judge = 0; RoBIF_next_pc = 32'h300;
    tick; tick;
    check("freeze IFIC_addr", IFIC_addr, 32'h200);
    Sys_rdy = 1; RoBIF_pre_judge = 1;
    ICIF_en = 1; ICIF_data = ADDI;
    tick;
    ICIF_en = 0;
    wait_dc("post-flush", 32'h200, ADDI, 0);
    // single-instruction vector table
    v[0] = '{32'h0, ADDI, 32'h4, 1'b0, 1'b0, 1'b1, 1'b0};
    v[1] = '{32'h0, enc_j(-8), 32'hFFFFFFF8, 1'b0, 1'b0, 1'b1, 1'b0};
    v[2] = '{32'h8, enc_b(32), 32'h28, 1'b1, 1'b1, 1'b1, 1'b1};
    v[3] = '{32'h8, enc_b(32), 32'hC, 1'b0, 1'b1, 1'b1, 1'b0};
    v[4] = '{32'h100, enc_b(-16), 32'hF0, 1'b1, 1'b1, 1'b1, 1'b1};
    v[5] = '{32'h40, enc_j(2048), 32'h840, 1'b1, 1'b0, 1'b1, 1'b0};
    v[6] = '{32'hC, JALR, 32'hC, 1'b0, 1'b0, 1'b0, 1'b0};
    v[7] = '{32'hFFFFFFFC, ADDI, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 8; i++) begin
      do_reset;
      if (i == 0) check("mid-op reset IFDC_pc", IFDC_pc, 0);
      ICIF_en = 1; ICIF_data = ADDI; RoBIF_pre_judge = 0; RoBIF_next_pc = v[i].start; DCIF_ask_IF = 1;
      tick;
      RoBIF_pre_judge = 1;
      check("vec start addr", IFIC_addr, v[i].start);
      ICIF_data = v[i].inst; PDIF_predict_result = v[i].pred;
      #1;
      check("vec predict_en", IFPD_predict_en, v[i].pen);
      check("vec IFPD_pc", IFPD_pc, v[i].start);
      tick;
      ICIF_en = 0;
      check("vec IFIC_en", IFIC_en, v[i].ifen);
      if (v[i].ifen) check("vec next addr", IFIC_addr, v[i].nxt);
      wait_dc("vec", v[i].start, v[i].inst, v[i].dpred);
    end
    // randomized run against the transaction-level model
    do_reset;
    q.delete();
    epc = 0; waiting = 0; draining = 0; busy = 0; pben = 0; pbres = 0; pbpc = 0; jcnt = 0; lat = 0;
    for (int c = 0; c < 3000; c++) begin
      if (IFDC_en) begin
        if (q.size() == 0) check("rnd spurious IFDC_en", IFDC_en, 0);
        else begin
          e = q.pop_front();
          check("rnd IFDC_pc", IFDC_pc, e.pc);
          check("rnd IFDC_inst", {IFDC_remain_inst, IFDC_opcode}, e.inst);
          check("rnd IFDC_pred", IFDC_predict_result, e.pred);
        end
      end
      check("rnd feedback_en", IFPD_feedback_en, pben);
      check("rnd branch_result", IFPD_branch_result, pbres);
      check("rnd feedback_pc", IFPD_feedback_pc, pbpc);
      exp_ifen = !waiting && !draining && q.size() < DEPTH;
      check("rnd IFIC_en", IFIC_en, exp_ifen);
      if (exp_ifen) check("rnd IFIC_addr", IFIC_addr, epc);
      if (!busy && IFIC_en) begin busy = 1; lat = $urandom_range(0, 2); end
      resp = 0;
      if (busy) begin
        if (lat == 0) begin resp = 1; busy = 0; end
        else lat--;
      end
      kind = $urandom_range(0, 19);
      isbr = kind >= 2 && kind <= 4;
      if (kind < 2) ICIF_data = JALR;
      else if (isbr) begin imm = ($urandom_range(0, 255) - 128) * 2; ICIF_data = enc_b(imm); end
      else if (kind <= 6) begin imm = ($urandom_range(0, 2047) - 1024) * 2; ICIF_data = enc_j(imm); end
      else begin
        ICIF_data = $urandom;
        if (ICIF_data[6:0] == 7'b1101111 || ICIF_data[6:0] == 7'b1100011 || ICIF_data[6:0] == 7'b1100111)
          ICIF_data[6:0] = 7'b0010011;
      end
      ICIF_en = resp;
      PDIF_predict_result = $urandom_range(0, 1);
      fl = $urandom_range(0, 29) == 0;
      RoBIF_pre_judge = !fl;
      RoBIF_next_pc = $urandom & 32'hFFFFFFFC;
      DCIF_ask_IF = $urandom_range(0, 3) != 0;
      je = 0;
      if (waiting && !fl) begin
        if (jcnt == 0) begin je = 1; tgt = $urandom & 32'hFFFFFFFC; end
        else jcnt--;
      end
      RoBIF_jalr_en = je;
      if (je) RoBIF_next_pc = tgt;
      RoBIF_branch_en = $urandom_range(0, 3) == 0;
      RoBIF_branch_result = $urandom_range(0, 1);
      RoBIF_branch_pc = $urandom;
      #1;
      check("rnd predict_en", IFPD_predict_en, 32'(resp && !draining && isbr));
      if (resp && !draining && isbr) check("rnd IFPD_pc", IFPD_pc, epc);
      if (fl) begin
        draining = (exp_ifen || draining) && !resp;
        q.delete();
        epc = RoBIF_next_pc;
        waiting = 0;
      end else begin
        if (resp && draining) draining = 0;
        else if (resp) begin
          q.push_back('{epc, ICIF_data, isbr && PDIF_predict_result});
          if (kind < 2) begin waiting = 1; jcnt = $urandom_range(0, 4); end
          else if (isbr) epc = epc + (PDIF_predict_result ? 32'(imm) : 32'd4);
          else if (kind <= 6) epc = epc + 32'(imm);
          else epc = epc + 32'd4;
        end
        if (je) begin epc = tgt; waiting = 0; end
      end
      pben = RoBIF_branch_en; pbres = RoBIF_branch_result; pbpc = RoBIF_branch_pc;
      tick;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
